// File: rtl/sha256_compress_core.sv
// SHA-256 compression engine: ROUNDS_PER_CYC rounds per beat, W words pulled over valid/ready,
// hash state chained across blocks. Define SHA256_CMP_SHA224_EN to allow the SHA-224 IV.
module sha256_compress_core #(
   parameter int ROUNDS_PER_CYC = 1
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          start,
   input  logic                          first_block,
   input  logic                          mode_224,
   input  logic                          wt_valid,
   input  logic [32*ROUNDS_PER_CYC-1:0]  wt_data,
   output logic                          wt_ready,
   output logic [5:0]                    round_idx,
   output logic [255:0]                  digest,
   output logic                          busy,
   output logic                          done
);
   localparam int R = ROUNDS_PER_CYC;

   generate
      if (!(R == 1 || R == 2 || R == 4)) begin : g_bad_rounds
         $error("ROUNDS_PER_CYC must be 1, 2 or 4");
      end
   endgenerate

   typedef enum logic [2:0] {S_IDLE, S_LOAD, S_ROUND, S_FINAL, S_DONE} state_t;

   localparam logic [31:0] K [64] = '{
      32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
      32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
      32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
      32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
      32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
      32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
      32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
      32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
   };

   // Packed H7..H0, so index i is Hi and the vector is the digest layout.
   localparam logic [7:0][31:0] IV256 = {
      32'h5be0cd19, 32'h1f83d9ab, 32'h9b05688c, 32'h510e527f,
      32'ha54ff53a, 32'h3c6ef372, 32'hbb67ae85, 32'h6a09e667
   };

   logic [7:0][31:0] iv;
`ifdef SHA256_CMP_SHA224_EN
   localparam logic [7:0][31:0] IV224 = {
      32'hbefa4fa4, 32'h64f98fa7, 32'h68581511, 32'hffc00b31,
      32'hf70e5939, 32'h3070dd17, 32'h367cd507, 32'hc1059ed8
   };
   assign iv = mode_224 ? IV224 : IV256;
`else
   logic unused_mode_224;
   assign unused_mode_224 = mode_224;
   assign iv = IV256;
`endif

   function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
      return (x >> n) | (x << (32 - n));
   endfunction

   function automatic logic [31:0] bsig0(input logic [31:0] x);
      return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
   endfunction

   function automatic logic [31:0] bsig1(input logic [31:0] x);
      return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
   endfunction

   state_t           state_q, state_d;
   logic [7:0][31:0] h_q, h_d;
   logic [7:0][31:0] wv_q, wv_d;   // working vars, index 0 = a
   logic [5:0]       cnt_q, cnt_d;
   logic             busy_q, done_q, ready_q;
   logic [7:0][31:0] rv;
   logic [31:0]      t1, t2;
   logic [5:0]       kidx;

   always_comb begin
      state_d = state_q;
      h_d     = h_q;
      wv_d    = wv_q;
      cnt_d   = cnt_q;
      rv      = wv_q;
      t1      = '0;
      t2      = '0;
      kidx    = '0;
      unique case (state_q)
         S_IDLE: if (start) begin
            state_d = S_LOAD;
            if (first_block) h_d = iv;
         end
         S_LOAD: begin
            wv_d    = h_q;
            cnt_d   = '0;
            state_d = S_ROUND;
         end
         S_ROUND: if (wt_valid) begin
            for (int j = 0; j < R; j++) begin
               kidx = cnt_q + 6'(j);
               t1 = rv[7] + bsig1(rv[4]) + ((rv[4] & rv[5]) ^ (~rv[4] & rv[6]))
                  + K[kidx] + wt_data[32*j +: 32];
               t2 = bsig0(rv[0]) + ((rv[0] & rv[1]) ^ (rv[0] & rv[2]) ^ (rv[1] & rv[2]));
               rv = {rv[6], rv[5], rv[4], rv[3] + t1, rv[2], rv[1], rv[0], t1 + t2};
            end
            wv_d  = rv;
            cnt_d = cnt_q + 6'(R);   // wraps to 0 after round 63
            if (cnt_q == 6'(64 - R)) state_d = S_FINAL;
         end
         S_FINAL: begin
            for (int i = 0; i < 8; i++) h_d[i] = h_q[i] + wv_q[i];
            state_d = S_DONE;
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         h_q     <= '0;
         wv_q    <= '0;
         cnt_q   <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         ready_q <= 1'b0;
      end else begin
         state_q <= state_d;
         h_q     <= h_d;
         wv_q    <= wv_d;
         cnt_q   <= cnt_d;
         busy_q  <= (state_d == S_LOAD) || (state_d == S_ROUND) || (state_d == S_FINAL);
         done_q  <= (state_d == S_DONE);
         ready_q <= (state_d == S_ROUND);
      end
   end

   assign wt_ready  = ready_q;
   assign busy      = busy_q;
   assign done      = done_q;
   assign round_idx = cnt_q;
   assign digest    = h_q;
endmodule

// File: tb/tb_sha256_compress_core.sv
// Directed bench for sha256_compress_core: R=1 and R=4 instances, known-answer digests,
// latency, stall, reset-abort and ignored-start behaviour.
module tb_sha256_compress_core;
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic         rst, start, first_block, mode_224, wt_valid, sel4;
   logic [127:0] wdat;
   logic         ready1, busy1, done1, ready4, busy4, done4;
   logic [5:0]   idx1, idx4;
   logic [255:0] dig1, dig4;

   sha256_compress_core #(.ROUNDS_PER_CYC(1)) dut1 (
      .clk(clk), .rst(rst), .start(start & ~sel4), .first_block(first_block),
      .mode_224(mode_224), .wt_valid(wt_valid & ~sel4), .wt_data(wdat[31:0]),
      .wt_ready(ready1), .round_idx(idx1), .digest(dig1), .busy(busy1), .done(done1));

   sha256_compress_core #(.ROUNDS_PER_CYC(4)) dut4 (
      .clk(clk), .rst(rst), .start(start & sel4), .first_block(first_block),
      .mode_224(mode_224), .wt_valid(wt_valid & sel4), .wt_data(wdat),
      .wt_ready(ready4), .round_idx(idx4), .digest(dig4), .busy(busy4), .done(done4));

   logic         o_ready, o_busy, o_done;
   logic [5:0]   o_idx;
   logic [255:0] o_dig;
   assign o_ready = sel4 ? ready4 : ready1;
   assign o_busy  = sel4 ? busy4  : busy1;
   assign o_done  = sel4 ? done4  : done1;
   assign o_idx   = sel4 ? idx4   : idx1;
   assign o_dig   = sel4 ? dig4   : dig1;

   localparam logic [255:0] ABC_256 = {32'hf20015ad, 32'hb410ff61, 32'h96177a9c, 32'hb00361a3,
                                       32'h5dae2223, 32'h414140de, 32'h8f01cfea, 32'hba7816bf};
   localparam logic [255:0] TWO_256 = {32'h19db06c1, 32'hf6ecedd4, 32'h64ff2167, 32'ha33ce459,
                                       32'h0c3e6039, 32'he5c02693, 32'hd20638b8, 32'h248d6a61};
   localparam logic [223:0] ABC_224 = {32'he36c9da7, 32'hbda0b3f7, 32'h2aadbce4, 32'hbda255b3,
                                       32'h8642a477, 32'h3405d822, 32'h23097d22};
   localparam logic [511:0] ABC_BLK  = {32'h61626380, {14{32'h0}}, 32'h00000018};
   localparam logic [511:0] TWO_BLK1 = {32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
                                        32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
                                        32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
                                        32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000};
   localparam logic [511:0] TWO_BLK2 = {{15{32'h0}}, 32'h000001c0};

   logic [31:0] w [64];
   int errors = 0;
   int checks = 0;

   task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] rr(input logic [31:0] x, input int n);
      return (x >> n) | (x << (32 - n));
   endfunction

   // Message schedule expansion (stands in for the scheduler feeding the engine).
   task automatic set_block(input logic [511:0] m);
      for (int i = 0; i < 16; i++) w[i] = m[511 - 32*i -: 32];
      for (int i = 16; i < 64; i++)
         w[i] = (rr(w[i-2], 17) ^ rr(w[i-2], 19) ^ (w[i-2] >> 10)) + w[i-7]
              + (rr(w[i-15], 7) ^ rr(w[i-15], 18) ^ (w[i-15] >> 3)) + w[i-16];
   endtask

   // Runs one block; de = edge after which done was seen (-1 timeout, -2 aborted by reset).
   task automatic run(input bit r4, input bit first, input bit m224,
                      input int stall_at, input int stall_len, input int pulse_at, input int rst_at,
                      output int de, output int bc, output int ie);
      int rpc, bcnt, stalled, edge_n, idx;
      bit consumed, pulsed;
      rpc = r4 ? 4 : 1;
      bcnt = 0; stalled = 0; edge_n = 0; pulsed = 0;
      de = -1; bc = 0; ie = 0;
      @(negedge clk);
      sel4 = r4; start = 1'b1; first_block = first; mode_224 = m224; wt_valid = 1'b1;
      for (int j = 0; j < 4; j++) wdat[32*j +: 32] = w[j];
      @(posedge clk);
      #1 start = 1'b0;
      for (int cyc = 0; cyc < 300; cyc++) begin
         @(negedge clk);
         if (o_busy) bc++;
         if (o_idx !== (o_ready ? 6'(bcnt) : 6'd0)) ie++;
         if (o_done) begin
            de = edge_n;
            break;
         end
         if (rst_at >= 0 && o_ready && bcnt == rst_at) begin
            rst = 1'b1;
            @(posedge clk);
            #1 rst = 1'b0;
            de = -2;
            break;
         end
         start = (pulse_at >= 0 && !pulsed && o_ready && bcnt == pulse_at);
         if (start) pulsed = 1'b1;
         if (stall_len > 0 && o_ready && bcnt == stall_at && stalled < stall_len) begin
            wt_valid = 1'b0;
            stalled++;
         end else wt_valid = 1'b1;
         for (int j = 0; j < 4; j++) begin
            idx = bcnt + j;
            wdat[32*j +: 32] = (idx < 64) ? w[idx] : 32'h0;
         end
         consumed = o_ready && wt_valid;
         @(posedge clk);
         edge_n++;
         if (consumed) bcnt += rpc;
      end
      start = 1'b0;
      wt_valid = 1'b0;
   endtask

   int de, bc, ie;

   initial begin
      rst = 1'b1; start = 1'b0; first_block = 1'b0; mode_224 = 1'b0;
      wt_valid = 1'b1; sel4 = 1'b0; wdat = '0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("rst_busy",  256'(o_busy), 256'(0));
      chk("rst_done",  256'(o_done), 256'(0));
      chk("rst_ready", 256'(o_ready), 256'(0));
      chk("rst_idx",   256'(o_idx), 256'(0));
      chk("rst_digest", o_dig, 256'(0));

      set_block(ABC_BLK);
      run(0, 1, 0, -1, 0, -1, -1, de, bc, ie);
      chk("abc_r1_digest", o_dig, ABC_256);
      chk("abc_r1_done_edge", 256'(de), 256'(66));
      chk("abc_r1_busy_cycles", 256'(bc), 256'(66));
      chk("abc_r1_round_idx", 256'(ie), 256'(0));

      set_block(TWO_BLK1);
      run(0, 1, 0, -1, 0, -1, -1, de, bc, ie);
      set_block(TWO_BLK2);
      run(0, 0, 0, -1, 0, -1, -1, de, bc, ie);
      chk("chain_digest", o_dig, TWO_256);
      chk("chain_done_edge", 256'(de), 256'(66));

      set_block(ABC_BLK);
      run(0, 1, 1, -1, 0, -1, -1, de, bc, ie);
`ifdef SHA256_CMP_SHA224_EN
      chk("sha224_digest", 256'(o_dig[223:0]), 256'(ABC_224));
`else
      chk("sha224_off_digest", o_dig, ABC_256);
`endif
      mode_224 = 1'b0;

      run(0, 1, 0, 20, 10, -1, -1, de, bc, ie);
      chk("stall_digest", o_dig, ABC_256);
      chk("stall_done_edge", 256'(de), 256'(76));
      chk("stall_busy_cycles", 256'(bc), 256'(76));
      chk("stall_round_idx", 256'(ie), 256'(0));

      run(1, 1, 0, -1, 0, -1, -1, de, bc, ie);
      chk("r4_digest", o_dig, ABC_256);
      chk("r4_done_edge", 256'(de), 256'(18));
      chk("r4_busy_cycles", 256'(bc), 256'(18));
      chk("r4_round_idx", 256'(ie), 256'(0));

      run(0, 1, 0, -1, 0, -1, 30, de, bc, ie);
      chk("abort_reached", 256'(de), 256'(-2));
      @(negedge clk);
      chk("abort_busy",   256'(o_busy), 256'(0));
      chk("abort_done",   256'(o_done), 256'(0));
      chk("abort_ready",  256'(o_ready), 256'(0));
      chk("abort_idx",    256'(o_idx), 256'(0));
      chk("abort_digest", o_dig, 256'(0));

      run(0, 1, 0, -1, 0, 40, -1, de, bc, ie);
      chk("pulse_digest", o_dig, ABC_256);
      chk("pulse_done_edge", 256'(de), 256'(66));
      chk("pulse_round_idx", 256'(ie), 256'(0));

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/sha256_compress_core.md
# sha256_compress_core

Parametrised SHA-256 message-compression engine; next generation of the single-round, multi-step compression block. It computes 1, 2 or 4 rounds per clock and pulls W words from the message scheduler through a valid/ready handshake, so the scheduler can stall the engine. It chains the hash state across multiple 512-bit blocks and can optionally start from the SHA-224 IV. It sits between the message scheduler and the SoC bus wrapper that reads the digest.

## Interface

- `ROUNDS_PER_CYC`, default 1: rounds computed per ROUND cycle.
  - Legal values are 1, 2 and 4; any other value is an elaboration error.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: reset, synchronous, active-high.
- `start` in 1: starts a block; sampled only in IDLE.
- `first_block` in 1: sampled with `start`.
  - 1: load the IV into H.
  - 0: chain from the current H.
- `mode_224` in 1: sampled with `start` when `first_block`=1; selects the SHA-224 IV (see Configuration).
- `wt_valid` in 1: `wt_data` is valid.
- `wt_data` in 32*ROUNDS_PER_CYC: W words; round t+j is in bits [32j+31:32j].
- `wt_ready` out 1: engine consumes `wt_data` this cycle.
- `round_idx` out 6: index of the first round of the current beat (0..63).
- `digest` out 256: {H7,H6,H5,H4,H3,H2,H1,H0}, with H0 at [31:0].
- `busy` out 1: high in states LOAD, ROUND and FINAL.
- `done` out 1: high only in state DONE (one cycle).

## Operation

- States: IDLE → LOAD → ROUND → FINAL → DONE → IDLE.
- IDLE:
  - On `start`=1 with `first_block`=1, H0..H7 <= IV.
  - On `start`=1 with `first_block`=0, H is unchanged.
  - On `start`=1, the next state is LOAD; `start`=0 stays in IDLE.
- LOAD: a..h <= H0..H7; round_cnt <= 0; go to ROUND.
- ROUND:
  - `wt_ready`=1.
  - On `wt_valid`=1, apply ROUNDS_PER_CYC chained rounds combinationally.
  - Each round j uses Kt[round_cnt+j] (internal 64-entry constant ROM) and W = word j of `wt_data`.
  - Per round: T1 = h+Σ1(e)+Ch(e,f,g)+K+W; T2 = Σ0(a)+Maj(a,b,c).
  - Shift: a..h <= {T1+T2, a, b, c, d+T1, e, f, g}.
  - After the beat, round_cnt += ROUNDS_PER_CYC.
  - After the beat that covers round 63, go to FINAL.
  - On `wt_valid`=0: a..h and round_cnt hold and no round is performed.
- FINAL: all eight updates happen in one cycle, Hi <= Hi + working_i; go to DONE.
- DONE: `done`=1; go to IDLE unconditionally.
- Arithmetic: every addition is modulo 2^32; carries are discarded.
- `round_idx` = round_cnt. It is 0 outside ROUND.
- `digest` follows the H registers.
  - It is stable from DONE until the next FINAL.
  - It can also change when IV is loaded by an IDLE `start` with `first_block`=1.
- `start` outside IDLE (including DONE) is ignored; it is not queued.
- `first_block`=0 directly after reset chains from H=0. This is legal, defined behaviour.
- `wt_valid` outside ROUND is ignored; `wt_ready`=0 there.

## Timing

- Reset values: state IDLE; H0..H7=0; a..h=0; round_cnt=0; `busy`=0; `done`=0; `wt_ready`=0; `round_idx`=0; `digest`=0.
- Reset mid-operation: the next cycle is IDLE with all reset values; the partial block is discarded.
- `rst` has priority over `start` and `wt_valid`.
- Latency, stall-free, counting from the edge that samples `start` (E0):
  - LOAD follows E0.
  - ROUND beats occupy edges E2..E(1+64/R).
  - FINAL follows E(1+64/R).
  - `done` is high in the cycle after E(2+64/R).
  - R=1: `done` after edge 66; `busy` high for 66 cycles.
  - R=4: `done` after edge 18; `busy` high for 18 cycles.
- Every cycle with `wt_valid`=0 in ROUND delays `done` by exactly one cycle.
- All outputs are registered or decoded directly from state; there is no combinational path from `start` or `wt_valid` to `busy` or `done`.

## Configuration

- Macro: `SHA256_CMP_SHA224_EN`.
- Defined:
  - `mode_224`=1 with `first_block`=1 loads the SHA-224 IV: c1059ed8 367cd507 3070dd17 f70e5939 ffc00b31 68581511 64f98fa7 befa4fa4.
  - The full 256-bit `digest` is still produced; the consumer uses H0..H6.
- Undefined:
  - The `mode_224` port remains but is ignored.
  - The SHA-256 IV (6a09e667 … 5be0cd19) is always loaded.
  - The SHA-224 IV constants are not synthesised.

## Test plan

- **"abc", R=1:** single padded block, `first_block`=1, `mode_224`=0, `wt_valid` held high.
  - `digest` H0..H7 = ba7816bf 8f01cfea 414140de 5dae2223 b00361a3 96177a9c b410ff61 f20015ad.
  - `done` after edge 66; `busy` high for exactly 66 cycles.
- **Two-block chaining:** 448-bit message "abcdbcdecdefdefgefghfghighijhijkijkljklmklmnlmnomnopnopq", block 1 with `first_block`=1, block 2 with `first_block`=0.
  - Final `digest` = 248d6a61 d20638b8 e5c02693 0c3e6039 a33ce459 64ff2167 f6ecedd4 19db06c1.
- **SHA-224:** `SHA256_CMP_SHA224_EN` defined, "abc", `mode_224`=1.
  - H0..H6 = 23097d22 3405d822 8642a477 bda255b3 2aadbce4 bda0b3f7 e36c9da7.
  - Same stimulus with the macro undefined gives the SHA-256 "abc" digest.
- **Stall:** R=1, `wt_valid`=0 for 10 cycles starting at `round_idx`=20.
  - `round_idx` holds at 20 for the stall.
  - `digest` is the "abc" value; `done` arrives 10 cycles later (after edge 76).
- **Unrolled, R=4:** "abc" block.
  - Same digest as the R=1 test.
  - `round_idx` steps 0,4,…,60; `done` after edge 18.
- **Reset and ignored start:**
  - Assert `rst` for one cycle at `round_idx`=30: next cycle `busy`=0, `done`=0, `wt_ready`=0, `digest`=0.
  - A new "abc" run then gives the correct digest.
  - A `start` pulse during ROUND has no effect on the result or the timing.
